// File: rtl/wb_gpio_bank_if.sv
// Wishbone slave bus bundle for wb_gpio_bank: address, data, lane selects and handshake.
interface wb_gpio_bank_if;
  logic [5:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: direction, set/clear outputs, synchronised inputs, edge interrupts.
// Optional alternate-function pin routing is built when GPIO_ALTFN_EN is defined.
module wb_gpio_bank #(
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  wb_gpio_bank_if.slave         wb,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_WIDTH-1:0] alt_o,
  input  logic [GPIO_WIDTH-1:0] alt_oe,
  output logic                  irq_o
);

  localparam logic [3:0] RegIn     = 4'h0;
  localparam logic [3:0] RegOut    = 4'h1;
  localparam logic [3:0] RegDir    = 4'h2;
  localparam logic [3:0] RegSet    = 4'h3;
  localparam logic [3:0] RegClr    = 4'h4;
  localparam logic [3:0] RegRiseEn = 4'h5;
  localparam logic [3:0] RegFallEn = 4'h6;
  localparam logic [3:0] RegStatus = 4'h7;
  localparam logic [3:0] RegAltsel = 4'h8;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] hist_q;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  irq_q;

  logic                  access, wr_en;
  logic [3:0]            reg_idx;
  logic [31:0]           lane_mask32;
  logic [GPIO_WIDTH-1:0] wmask, wdata, w1c;
  logic [GPIO_WIDTH-1:0] in_sync, rise, fall, edge_set;
  logic [31:0]           rdata;

`ifdef GPIO_ALTFN_EN
  logic [GPIO_WIDTH-1:0] altsel_q, altsel_d;
`endif

  // A new access is only accepted while ack is low, giving one transfer per two cycles.
  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_en   = access & wb.wb_we_i;
  assign reg_idx = wb.wb_adr_i[5:2];
  assign ack_d   = access;

  assign lane_mask32 = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                        {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign wmask       = lane_mask32[GPIO_WIDTH-1:0];
  assign wdata       = wb.wb_dat_i[GPIO_WIDTH-1:0];

  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign rise     = in_sync & ~hist_q;
  assign fall     = ~in_sync & hist_q;
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
`ifdef GPIO_ALTFN_EN
    altsel_d  = altsel_q;
`endif
    if (wr_en) begin
      case (reg_idx)
        RegOut:    out_d     = (out_q & ~wmask) | (wdata & wmask);
        RegDir:    dir_d     = (dir_q & ~wmask) | (wdata & wmask);
        RegSet:    out_d     = out_q | (wdata & wmask);
        RegClr:    out_d     = out_q & ~(wdata & wmask);
        RegRiseEn: rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
        RegFallEn: fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
        RegStatus: w1c       = wdata & wmask;
`ifdef GPIO_ALTFN_EN
        RegAltsel: altsel_d  = (altsel_q & ~wmask) | (wdata & wmask);
`endif
        default:   ;
      endcase
    end
    // A fresh edge beats a same-cycle clear so no event is lost.
    status_d = (status_q & ~w1c) | edge_set;
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      RegIn:     rdata = 32'(in_sync);
      RegOut:    rdata = 32'(out_q);
      RegDir:    rdata = 32'(dir_q);
      RegRiseEn: rdata = 32'(rise_en_q);
      RegFallEn: rdata = 32'(fall_en_q);
      RegStatus: rdata = 32'(status_q);
`ifdef GPIO_ALTFN_EN
      RegAltsel: rdata = 32'(altsel_q);
`endif
      default:   rdata = '0;
    endcase
    dat_d = (access & ~wb.wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_q     <= OUT_RESET;
      dir_q     <= DIR_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      hist_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q    <= in_sync;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= |status_q;
    end
  end

`ifdef GPIO_ALTFN_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) altsel_q <= '0;
    else             altsel_q <= altsel_d;
  end

  assign gpio_o  = (altsel_q & alt_o)  | (~altsel_q & out_q);
  assign gpio_oe = (altsel_q & alt_oe) | (~altsel_q & dir_q);

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i, lane_mask32};
`else
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

  // Alternate-function inputs have no effect in this build.
  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i, lane_mask32, alt_o, alt_oe};
`endif

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

endmodule
